// File: rtl/fu2_pkg.sv
// Package fu2_pkg: shared constants for the fu2 writeback stage.
// Result entries are packed MSB-first as {data, tag, flags}; flags are {Z,N,R,O}.
package fu2_pkg;

   localparam int FU2_DSIZE = 64;   // fu2 OUT width
   localparam int FU2_TSIZE = 4;    // destination tag width
   localparam int FU2_LAT   = 2;    // fu2 operand-sample to result latency
   localparam int FU2_DEPTH = 4;    // result FIFO entries

   localparam int FLAG_W = 4;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_R = 1;
   localparam int FLAG_O = 0;

   // Default-size result entry, for reference by users of the stage
   typedef struct packed {
      logic [FU2_DSIZE-1:0] data;
      logic [FU2_TSIZE-1:0] tag;
      logic [FLAG_W-1:0]    flags;
   } fu2_entry_t;

   // Width of one packed {data, tag, flags} entry
   function automatic int entry_width(input int dsize, input int tsize);
      return dsize + tsize + FLAG_W;
   endfunction

endpackage

// File: rtl/fu2_wb_fifo.sv
// fu2_wb_fifo: DEPTH x W synchronous FIFO with a registered head.
// The head register only changes on a pop or on a push into an empty FIFO, so it
// keeps the last popped value while empty. A push while full is accepted only
// when a pop happens at the same edge.
module fu2_wb_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic [W-1:0]           push_data_i,
   input  logic                   pop_i,
   output logic [W-1:0]           head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] rd_next;
   logic [CW-1:0] count_q, count_d;
   logic [W-1:0]  head_q, head_d;
   logic          push_ok, pop_ok, full, empty;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // Accept decisions and next state for storage, pointers, count and head
   always_comb begin
      pop_ok   = pop_i && !empty;
      push_ok  = push_i && (!full || pop_ok);
      rd_next  = rd_ptr_q + AW'(1);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_next;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Head follows the next stored entry, or the incoming one when that is all there is
      if (pop_ok) begin
         if (count_q > CW'(1)) begin
            head_d = mem_q[rd_next];
         end else if (push_ok) begin
            head_d = push_data_i;
         end
      end else if (push_ok && empty) begin
         head_d = push_data_i;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   assign head_o  = head_q;
   assign count_o = count_q;
   assign full_o  = full;
   assign empty_o = empty;

endmodule

// File: rtl/fu2_wb.sv
// fu2_wb: writeback stage behind fu2. A FU_LAT-deep {vld,tag} delay line pairs each
// fu2 result with its tag, results go into a small FIFO drained by a valid/ready
// consumer, and credits (FIFO count + ops in flight) gate upstream issue.
// Handshake: a head result transfers at an edge where WB_VLD and WB_RDY are both high;
// WB_* are registered and only meaningful while WB_VLD is high.
// Optional feature macro: FU2_WB_PARITY_EN adds WB_PAR = ^{WB_DATA,WB_TAG,WB_FLAGS}.
module fu2_wb
   import fu2_pkg::*;
#(
   parameter int DSIZE  = FU2_DSIZE,
   parameter int TSIZE  = FU2_TSIZE,
   parameter int FU_LAT = FU2_LAT,
   parameter int DEPTH  = FU2_DEPTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ISSUE_VLD,
   input  logic [TSIZE-1:0] ISSUE_TAG,
   output logic             ISSUE_RDY,
   input  logic [DSIZE-1:0] FU_OUT,
   input  logic             FU_Z,
   input  logic             FU_N,
   input  logic             FU_R,
   input  logic             FU_O,
   output logic             WB_VLD,
   input  logic             WB_RDY,
   output logic [DSIZE-1:0] WB_DATA,
   output logic [TSIZE-1:0] WB_TAG,
   output logic [3:0]       WB_FLAGS,
`ifdef FU2_WB_PARITY_EN
   output logic             WB_PAR,
`endif
   output logic [3:0]       STICKY,
   input  logic             STICKY_CLR,
   output logic [7:0]       DROP_CNT
);

   localparam int EW = entry_width(DSIZE, TSIZE);
`ifdef FU2_WB_PARITY_EN
   localparam int FW = EW + 1;
`else
   localparam int FW = EW;
`endif
   localparam int CW = $clog2(DEPTH) + 1;

   logic [FU_LAT-1:0] vld_q, vld_d;
   logic [TSIZE-1:0]  tag_q [FU_LAT];
   logic [TSIZE-1:0]  tag_d [FU_LAT];
   logic [3:0]        sticky_q, sticky_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;

   logic [FLAG_W-1:0] fu_flags;
   logic [EW-1:0]     entry;
   logic [FW-1:0]     push_data;
   logic [FW-1:0]     head;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full, fifo_empty;
   logic              push, pop, accept, drop;
   int                inflight;

   // Delay line: issue enters stage 0, stage FU_LAT-1 marks the result present on FU_OUT
   always_comb begin
      vld_d    = '0;
      vld_d[0] = ISSUE_VLD;
      tag_d[0] = ISSUE_TAG;
      for (int i = 1; i < FU_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         tag_d[i] = tag_q[i-1];
      end
   end

   // Ops still travelling through fu2 hold a credit each
   always_comb begin
      inflight = 0;
      for (int i = 0; i < FU_LAT; i++) begin
         if (vld_q[i]) inflight = inflight + 1;
      end
   end

   assign ISSUE_RDY = (inflight + int'(fifo_count)) < DEPTH;

   // Result capture, accept/drop decision, sticky flags and drop counter
   always_comb begin
      fu_flags         = '0;
      fu_flags[FLAG_Z] = FU_Z;
      fu_flags[FLAG_N] = FU_N;
      fu_flags[FLAG_R] = FU_R;
      fu_flags[FLAG_O] = FU_O;
      entry            = {FU_OUT, tag_q[FU_LAT-1], fu_flags};
`ifdef FU2_WB_PARITY_EN
      push_data        = {^entry, entry};
`else
      push_data        = entry;
`endif
      push       = vld_q[FU_LAT-1];
      pop        = !fifo_empty && WB_RDY;
      accept     = push && (!fifo_full || pop);
      drop       = push && fifo_full && !pop;
      sticky_d   = (STICKY_CLR ? 4'b0000 : sticky_q) | (accept ? fu_flags : 4'b0000);
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   // Delay line, sticky flags and drop counter registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_q      <= '0;
         for (int i = 0; i < FU_LAT; i++) begin
            tag_q[i] <= '0;
         end
         sticky_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         vld_q      <= vld_d;
         tag_q      <= tag_d;
         sticky_q   <= sticky_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   fu2_wb_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (CLK),
      .rst         (RST),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (WB_RDY),
      .head_o      (head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign WB_VLD   = !fifo_empty;
   assign WB_DATA  = head[EW-1 -: DSIZE];
   assign WB_TAG   = head[FLAG_W +: TSIZE];
   assign WB_FLAGS = head[FLAG_W-1:0];
`ifdef FU2_WB_PARITY_EN
   assign WB_PAR   = head[EW];
`endif
   assign STICKY   = sticky_q;
   assign DROP_CNT = drop_cnt_q;

endmodule
